// File: rtl/carry_chain_seq.sv
// Multi-word add/subtract sequencer. It splits a wide operation into
// WORD_SIZE slices, least-significant word first, and feeds each slice to an
// external combinational adder stage. Subtraction is done as x + ~y + 1:
// the borrow travels through the adder's ordinary carry path, so the adder's
// own sub mode is never used. Each accepted word produces one registered
// result word with a single output buffer and a ready/valid handshake.
// Chain flags (carry, zero, overflow) are valid on the last word.
module carry_chain_seq #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_x,
    input  logic [WORD_SIZE-1:0] in_y,
    input  logic                 in_sub,
    input  logic                 in_last,
    output logic [WORD_SIZE-1:0] as_x,
    output logic [WORD_SIZE-1:0] as_y,
    output logic                 as_sub,
    output logic                 as_carry,
    output logic                 as_cin,
    input  logic [WORD_SIZE-1:0] as_sum,
    input  logic                 as_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_sum,
    output logic                 out_last,
    output logic                 out_c,
    output logic                 out_z,
    output logic                 out_v
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic sub_q;
    logic carry_q;
    logic zacc;
    logic first;
    logic eff_sub;
    logic accept;
    logic zacc_next;
    logic ovf;

    // The adder always runs in plain add mode with its carry input enabled.
    assign as_sub   = 1'b0;
    assign as_carry = 1'b1;

    // A new word can enter whenever the output buffer is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // State register: IDLE means the next accepted word starts a new chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a non-last word enters or stays in CHAIN, a last word ends it.
    always_comb begin
        state_next = state;
        if (accept) begin
            if (in_last) begin
                state_next = IDLE;
            end else begin
                state_next = CHAIN;
            end
        end
    end

    // Adder operands: the operation is picked on the first word, later words
    // take the carry of the previous word as their carry-in.
    always_comb begin
        first   = (state == IDLE);
        eff_sub = first ? in_sub : sub_q;
        as_x    = in_x;
        as_y    = eff_sub ? ~in_y : in_y;
        as_cin  = first ? eff_sub : carry_q;
    end

    // Flag terms derived from the adder result of the word being offered.
    always_comb begin
        zacc_next = (first || zacc) && (as_sum == '0);
        ovf       = (as_x[WORD_SIZE-1] == as_y[WORD_SIZE-1]) &&
                    (as_sum[WORD_SIZE-1] != as_x[WORD_SIZE-1]);
    end

    // Datapath and output buffer: load on accept, otherwise hold and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_c     <= 1'b0;
            out_z     <= 1'b0;
            out_v     <= 1'b0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            zacc      <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= as_sum;
            out_last  <= in_last;
            out_c     <= as_cout;
            out_z     <= zacc_next;
            out_v     <= ovf;
            carry_q   <= as_cout;
            zacc      <= zacc_next;
            if (first && !in_last) begin
                sub_q <= in_sub;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_carry_chain_seq.sv
// Directed testbench for carry_chain_seq. A behavioural adder stage closes
// the as_* loop; a table of per-word vectors with hand-computed results is
// applied in a loop, followed by hand-written backpressure and reset cases.
module tb_carry_chain_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_sub;
    logic         in_last;
    logic [W-1:0] as_x;
    logic [W-1:0] as_y;
    logic         as_sub;
    logic         as_carry;
    logic         as_cin;
    logic [W-1:0] as_sum;
    logic         as_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_c;
    logic         out_z;
    logic         out_v;

    logic [W:0]   add_full;

    int n_compared;
    int n_failed;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         sub;
        logic         last;
        logic [W-1:0] sum;
        logic         c;
        logic         z;
        logic         v;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    carry_chain_seq #(.WORD_SIZE(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_sub   (in_sub),
        .in_last  (in_last),
        .as_x     (as_x),
        .as_y     (as_y),
        .as_sub   (as_sub),
        .as_carry (as_carry),
        .as_cin   (as_cin),
        .as_sum   (as_sum),
        .as_cout  (as_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_c    (out_c),
        .out_z    (out_z),
        .out_v    (out_v)
    );

    // Behavioural adder stage: plain add with gated carry-in.
    assign add_full = {1'b0, as_x} + {1'b0, as_y} + {{W{1'b0}}, as_cin & as_carry};
    assign as_sum   = add_full[W-1:0];
    assign as_cout  = add_full[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one word and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sub, input logic last, input string name);
        bit got;
        @(negedge clk);
        in_x     = x;
        in_y     = y;
        in_sub   = sub;
        in_last  = last;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL %s accept timeout: in_ready stayed 0, expected 1", name);
        end
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] sum, input logic last,
                               input logic c, input logic z, input logic v);
        checkField({name, " valid"}, {31'b0, out_valid}, 32'd1);
        checkField({name, " sum"},   {16'b0, out_sum},   {16'b0, sum});
        checkField({name, " last"},  {31'b0, out_last},  {31'b0, last});
        if (last) begin
            checkField({name, " c"}, {31'b0, out_c}, {31'b0, c});
            checkField({name, " z"}, {31'b0, out_z}, {31'b0, z});
            checkField({name, " v"}, {31'b0, out_v}, {31'b0, v});
        end
    endtask

    initial begin
        n_compared = 0;
        n_failed   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_y       = '0;
        in_sub     = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // x, y, sub, last, expected sum, c, z, v (flags only on last words)
        vecs[0]  = '{16'h0001, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h9ABC, 16'h9ABC, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h5678, 16'h5678, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        checkField("reset in_ready",  {31'b0, in_ready},  32'd1);
        checkField("reset out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkField("post-reset out_sum", {16'b0, out_sum}, 32'd0);
        checkField("post-reset flags", {29'b0, out_last, out_c, out_z}, 32'd0);
        checkField("post-reset out_v", {31'b0, out_v}, 32'd0);
        checkField("as_sub tie",   {31'b0, as_sub},   32'd0);
        checkField("as_carry tie", {31'b0, as_carry}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].sub, vecs[i].last, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d", i), vecs[i].sum, vecs[i].last,
                        vecs[i].c, vecs[i].z, vecs[i].v);
        end

        @(posedge clk);
        #1;
        checkField("drain out_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] backpressure sequence");
        applyStimulus(16'h0002, 16'h0003, 1'b0, 1'b1, "bp first");
        checkOutput("bp first", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_x      = 16'h0010;
        in_y      = 16'h0020;
        in_sub    = 1'b0;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            checkField($sformatf("bp stall%0d in_ready", j), {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            checkField($sformatf("bp stall%0d sum", j), {16'b0, out_sum}, 32'h0005);
            checkField($sformatf("bp stall%0d valid", j), {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkField("bp release in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp second", 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-chain sequence");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, "rst word0");
        checkOutput("rst word0", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkField("rst out_valid", {31'b0, out_valid}, 32'd0);
        checkField("rst in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_x     = 16'h0000;
        in_y     = 16'h0000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        #1;
        checkField("rst as_cin", {31'b0, as_cin}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("rst word1", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
